// File: rtl/strobe_pkg.sv
// Shared types and defaults for the symbol strobe phase controller.
package strobe_pkg;

    localparam int PERIOD_DEF = 20;
    localparam int PTR_W      = $clog2(PERIOD_DEF);

    // Direction of a pending phase correction requested by the vote integrator.
    typedef enum logic [1:0] {
        ADJ_NONE = 2'd0,
        ADJ_ADV  = 2'd1,
        ADJ_RET  = 2'd2
    } adj_dir_t;

    // Lock indicator states.
    typedef enum logic {
        ACQ    = 1'b0,
        LOCKED = 1'b1
    } lock_st_t;

endpackage

// File: rtl/phase_vote_acc.sv
// Saturating signed integrator of early/late votes from the timing error
// detector; reports which way the phase should move once the net vote
// reaches the threshold.
module phase_vote_acc
    import strobe_pkg::*;
#(
    parameter int VOTE_TH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     vld,
    input  logic     early,
    input  logic     late,
    input  logic     clr,
    output adj_dir_t dir
);

    localparam int AW = $clog2(VOTE_TH + 1) + 1;
    localparam logic signed [AW-1:0] TH_POS = AW'(VOTE_TH);
    localparam logic signed [AW-1:0] TH_NEG = AW'(-VOTE_TH);

    logic signed [AW-1:0] acc_r;
    logic signed [AW-1:0] acc_nxt_s;

    // Next accumulator value: clear wins, otherwise a single-sided vote moves it one step.
    always_comb begin
        acc_nxt_s = acc_r;
        if (clr) begin
            acc_nxt_s = AW'(0);
        end else if (vld && early && !late && (acc_r != TH_POS)) begin
            acc_nxt_s = acc_r + AW'(1);
        end else if (vld && late && !early && (acc_r != TH_NEG)) begin
            acc_nxt_s = acc_r - AW'(1);
        end else begin
            acc_nxt_s = acc_r;
        end
    end

    // Accumulator register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_r <= AW'(0);
        end else begin
            acc_r <= acc_nxt_s;
        end
    end

    // Saturated positive means early strobes (retard); saturated negative means advance.
    always_comb begin
        dir = ADJ_NONE;
        if (acc_r == TH_POS) begin
            dir = ADJ_RET;
        end else if (acc_r == TH_NEG) begin
            dir = ADJ_ADV;
        end else begin
            dir = ADJ_NONE;
        end
    end

endmodule

// File: rtl/strobe_phase_ctrl.sv
// Closed-loop symbol strobe phase controller: symbol counter, phase pointer
// with safe-point +/-1 adjustment, software force-load and lock indication.
module strobe_phase_ctrl
    import strobe_pkg::*;
#(
    parameter int PERIOD   = PERIOD_DEF,
    parameter int PTR_INIT = 0,
    parameter int VOTE_TH  = 4,
    parameter int LOCK_CNT = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en_i,
    input  logic                      ted_vld_i,
    input  logic                      early_i,
    input  logic                      late_i,
    input  logic                      ptr_ld_i,
    input  logic [$clog2(PERIOD)-1:0] ptr_val_i,
    output logic                      stb_o,
    output logic [$clog2(PERIOD)-1:0] ptr_o,
    output logic                      adj_o,
    output logic                      slip_o,
    output logic                      lock_o
);

    localparam int PW = $clog2(PERIOD);
    localparam int LW = $clog2(LOCK_CNT + 1);
    localparam logic [PW-1:0] LAST  = PW'(PERIOD - 1);
    localparam logic [LW-1:0] LFULL = LW'(LOCK_CNT);

    logic [PW-1:0] cnt_r, ptr_r;
    logic          skip_r, stb_r, adj_r, slip_r, lock_r;
    lock_st_t      state_r;
    logic [LW-1:0] lcnt_r;

    logic [PW-1:0] cnt_nxt_s, ptr_nxt_s;
    logic          skip_nxt_s, slip_nxt_s, lock_nxt_s;
    logic          match_s, fire_s, adj_s, clr_s;
    lock_st_t      state_nxt_s;
    logic [LW-1:0] lcnt_nxt_s;
    adj_dir_t      dir_s;

    phase_vote_acc #(
        .VOTE_TH (VOTE_TH)
    ) u_vote (
        .clk   (clk),
        .rst   (rst),
        .vld   (ted_vld_i),
        .early (early_i),
        .late  (late_i),
        .clr   (clr_s),
        .dir   (dir_s)
    );

    // Match qualification: a strobe fires on an unsuppressed match not pre-empted by a load.
    always_comb begin
        match_s = en_i && (cnt_r == ptr_r);
        fire_s  = match_s && !skip_r && !ptr_ld_i;
        adj_s   = fire_s && (dir_s != ADJ_NONE);
        clr_s   = adj_s || ptr_ld_i;
    end

    // Counter, pointer and skip next-state.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        ptr_nxt_s  = ptr_r;
        skip_nxt_s = skip_r;
        slip_nxt_s = 1'b0;
        if (en_i) begin
            cnt_nxt_s = (cnt_r == LAST) ? PW'(0) : cnt_r + PW'(1);
        end else begin
            cnt_nxt_s = cnt_r;
        end
        if (ptr_ld_i) begin
            ptr_nxt_s  = (ptr_val_i > LAST) ? LAST : ptr_val_i;
            skip_nxt_s = 1'b0;
        end else if (match_s && skip_r) begin
            skip_nxt_s = 1'b0;
        end else if (adj_s) begin
            case (dir_s)
                ADJ_RET: begin
                    // The moved pointer equals the very next count value, so that
                    // immediate match must be swallowed to avoid a double strobe.
                    ptr_nxt_s  = (ptr_r == LAST) ? PW'(0) : ptr_r + PW'(1);
                    skip_nxt_s = 1'b1;
                    slip_nxt_s = (ptr_r == LAST);
                end
                ADJ_ADV: begin
                    ptr_nxt_s  = (ptr_r == PW'(0)) ? LAST : ptr_r - PW'(1);
                    slip_nxt_s = (ptr_r == PW'(0));
                end
                default: begin
                    ptr_nxt_s = ptr_r;
                end
            endcase
        end else begin
            ptr_nxt_s = ptr_r;
        end
    end

    // Lock FSM next-state: clean strobes build confidence, any correction or load restarts it.
    always_comb begin
        state_nxt_s = state_r;
        lcnt_nxt_s  = lcnt_r;
        if (ptr_ld_i || adj_s) begin
            lcnt_nxt_s = LW'(0);
        end else if (fire_s && (lcnt_r != LFULL)) begin
            lcnt_nxt_s = lcnt_r + LW'(1);
        end else begin
            lcnt_nxt_s = lcnt_r;
        end
        case (state_r)
            ACQ: begin
                if (!ptr_ld_i && !adj_s && (lcnt_nxt_s == LFULL)) begin
                    state_nxt_s = LOCKED;
                end else begin
                    state_nxt_s = ACQ;
                end
            end
            LOCKED: begin
                if (ptr_ld_i || adj_s) begin
                    state_nxt_s = ACQ;
                end else begin
                    state_nxt_s = LOCKED;
                end
            end
            default: begin
                state_nxt_s = ACQ;
            end
        endcase
        lock_nxt_s = (state_nxt_s == LOCKED);
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r   <= PW'(0);
            ptr_r   <= PW'(PTR_INIT);
            skip_r  <= 1'b0;
            stb_r   <= 1'b0;
            adj_r   <= 1'b0;
            slip_r  <= 1'b0;
            lock_r  <= 1'b0;
            state_r <= ACQ;
            lcnt_r  <= LW'(0);
        end else begin
            cnt_r   <= cnt_nxt_s;
            ptr_r   <= ptr_nxt_s;
            skip_r  <= skip_nxt_s;
            stb_r   <= fire_s;
            adj_r   <= adj_s;
            slip_r  <= slip_nxt_s;
            lock_r  <= lock_nxt_s;
            state_r <= state_nxt_s;
            lcnt_r  <= lcnt_nxt_s;
        end
    end

    assign stb_o  = stb_r;
    assign ptr_o  = ptr_r;
    assign adj_o  = adj_r;
    assign slip_o = slip_r;
    assign lock_o = lock_r;

endmodule

// File: tb/tb_strobe_phase_ctrl.sv
// Bench for strobe_phase_ctrl: directed scenarios followed by random traffic,
// checked every cycle against an event-scheduling model of strobe timing.
module tb_strobe_phase_ctrl;

    localparam int P    = 20;
    localparam int PI   = 3;
    localparam int TH   = 4;
    localparam int LC   = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en_i = 1'b0, ted_vld_i = 1'b0, early_i = 1'b0, late_i = 1'b0, ptr_ld_i = 1'b0;
    logic [4:0] ptr_val_i = 5'd0;
    logic       stb_o, adj_o, slip_o, lock_o;
    logic [4:0] ptr_o;

    int checks = 0;
    int errors = 0;

    // Model: strobes are scheduled in units of enabled cycles.
    int m_k, m_next, m_ptr, m_acc, m_lc;
    logic e_stb, e_adj, e_slip, e_lock;

    strobe_phase_ctrl #(
        .PERIOD   (P),
        .PTR_INIT (PI),
        .VOTE_TH  (TH),
        .LOCK_CNT (LC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en_i      (en_i),
        .ted_vld_i (ted_vld_i),
        .early_i   (early_i),
        .late_i    (late_i),
        .ptr_ld_i  (ptr_ld_i),
        .ptr_val_i (ptr_val_i),
        .stb_o     (stb_o),
        .ptr_o     (ptr_o),
        .adj_o     (adj_o),
        .slip_o    (slip_o),
        .lock_o    (lock_o)
    );

    always #5 clk = ~clk;

    function automatic int pmod(input int a);
        return ((a % P) + P) % P;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cycle_k=%0d observed=%0h expected=%0h", tag, m_k, got, exp);
        end
    endtask

    task automatic step(input logic r, input logic en, input logic v, input logic e,
                        input logic l, input logic ld, input logic [4:0] val);
        bit adjd;
        @(negedge clk);
        rst = r; en_i = en; ted_vld_i = v; early_i = e; late_i = l;
        ptr_ld_i = ld; ptr_val_i = val;
        adjd = 1'b0;
        e_stb = 1'b0; e_adj = 1'b0; e_slip = 1'b0;
        if (!r) begin
            m_k = 0; m_ptr = PI; m_next = PI; m_acc = 0; m_lc = 0; e_lock = 1'b0;
        end else if (ld) begin
            m_ptr = (int'(val) > P - 1) ? P - 1 : int'(val);
            m_acc = 0; m_lc = 0; e_lock = 1'b0;
            if (en) m_k++;
            m_next = m_k + pmod(m_ptr - m_k);
        end else begin
            if (en) begin
                if (m_k == m_next) begin
                    e_stb = 1'b1;
                    if (m_acc == TH || m_acc == -TH) begin
                        adjd = 1'b1; e_adj = 1'b1;
                        if (m_acc > 0) begin
                            e_slip = (m_ptr == P - 1);
                            m_ptr  = pmod(m_ptr + 1);
                            m_next = m_k + P + 1;
                        end else begin
                            e_slip = (m_ptr == 0);
                            m_ptr  = pmod(m_ptr - 1);
                            m_next = m_k + P - 1;
                        end
                        m_acc = 0; m_lc = 0;
                    end else begin
                        m_next = m_k + P;
                        if (m_lc < LC) m_lc++;
                    end
                end
                m_k++;
            end
            if (!adjd && v && (e != l)) begin
                if (e) m_acc = (m_acc + 1 > TH) ? TH : m_acc + 1;
                else   m_acc = (m_acc - 1 < -TH) ? -TH : m_acc - 1;
            end
            e_lock = (m_lc >= LC);
        end
        @(posedge clk);
        #1;
        chk("stb",  32'(stb_o),  32'(e_stb));
        chk("adj",  32'(adj_o),  32'(e_adj));
        chk("slip", 32'(slip_o), 32'(e_slip));
        chk("lock", 32'(lock_o), 32'(e_lock));
        chk("ptr",  32'(ptr_o),  32'(m_ptr));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
    endtask

    task automatic vote(input logic e, input logic l);
        step(1'b1, 1'b1, 1'b1, e, l, 1'b0, 5'd0);
    endtask

    task automatic load(input logic [4:0] val);
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, val);
    endtask

    initial begin
        // Reset, then free-run long enough to lock at PTR_INIT.
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        idle(345);
        // Four early votes: retard 3 -> 4, lock drops.
        for (int i = 0; i < 4; i++) vote(1'b1, 1'b0);
        idle(50);
        // Retard wrap 19 -> 0 with skipped following match.
        load(5'd19);
        idle(3);
        for (int i = 0; i < 4; i++) vote(1'b1, 1'b0);
        idle(50);
        // Advance wrap 0 -> 19.
        load(5'd0);
        idle(3);
        for (int i = 0; i < 4; i++) vote(1'b0, 1'b1);
        idle(50);
        // Mixed votes net +3: no adjustment; one more early then adjusts.
        vote(1'b1, 1'b0); vote(1'b1, 1'b0); vote(1'b1, 1'b0);
        vote(1'b0, 1'b1); vote(1'b1, 1'b0); vote(1'b1, 1'b1);
        idle(45);
        vote(1'b1, 1'b0);
        idle(45);
        // Out-of-range load clamps to PERIOD-1.
        load(5'd25);
        idle(30);
        // Half-rate enable doubles the strobe interval.
        for (int i = 0; i < 100; i++)
            step(1'b1, (i % 2) == 0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        // Reset while an adjustment is pending.
        for (int i = 0; i < 4; i++) vote(1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0);
        idle(30);
        // Randomized traffic.
        for (int i = 0; i < 2500; i++) begin
            logic r, en, v, e, l, ld;
            logic [4:0] val;
            r   = ($urandom_range(0, 299) != 0);
            en  = ($urandom_range(0, 99) < 85);
            v   = ($urandom_range(0, 99) < 35);
            e   = 1'($urandom_range(0, 1));
            l   = 1'($urandom_range(0, 1));
            ld  = ($urandom_range(0, 149) == 0);
            val = 5'($urandom_range(0, 31));
            step(r, en, v, e, l, ld, val);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
